// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART frame receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } state_t;

  localparam logic [7:0] SOF_DEFAULT           = 8'hA5;
  localparam int         TIMEOUT_TICKS_DEFAULT = 640;

  // Frame checksum: XOR of start byte, command and data.
  function automatic logic [7:0] frame_chk(input logic [7:0] sof,
                                           input logic [7:0] cmd,
                                           input logic [7:0] data);
    return sof ^ cmd ^ data;
  endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// UART frame decoder: turns a byte stream of SOF, CMD, DATA[, CHK] into a
// held command/data pair with a valid/ready handshake, an inter-byte
// timeout and single-cycle error pulses.
// Build option: define UART_FRAME_CHK_EN for the 4-byte frame with checksum;
// left undefined, frames are 3 bytes and err_chk is tied low.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF           = SOF_DEFAULT,
  parameter int         TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       frm_valid,
  input  logic       frm_ready,
  output logic [7:0] frm_cmd,
  output logic [7:0] frm_data,
  output logic       err_chk,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       busy
);

  localparam int                 CNT_W    = $clog2(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cmd_q;
  logic [7:0]       data_q;
  logic             frame_done;
  logic             chk_bad;
  logic             tmo_hit;
  logic [7:0]       done_data;

  // A byte in the same cycle as the timeout wins, so the timeout needs a quiet cycle.
  assign tmo_hit = (state != ST_IDLE) && s_tick && !rx_done_tick && (cnt == CNT_LAST);
  assign busy    = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state decode; frame completion and checksum failure are flagged here.
  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    chk_bad    = 1'b0;
    done_data  = data_q;
    case (state)
      ST_IDLE: if (rx_done_tick && rx_data == SOF) state_n = ST_CMD;
      ST_CMD:  if (rx_done_tick) state_n = ST_DATA;
`ifdef UART_FRAME_CHK_EN
      ST_DATA: if (rx_done_tick) state_n = ST_CHK;
      ST_CHK: begin
        if (rx_done_tick) begin
          state_n = ST_IDLE;
          if (rx_data == frame_chk(SOF, cmd_q, data_q)) frame_done = 1'b1;
          else                                          chk_bad    = 1'b1;
        end
      end
`else
      ST_DATA: begin
        if (rx_done_tick) begin
          state_n    = ST_IDLE;
          frame_done = 1'b1;
          done_data  = rx_data;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
    if (tmo_hit) state_n = ST_IDLE;
  end

  // Capture command and data bytes of the frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q  <= 8'h00;
      data_q <= 8'h00;
    end else if (rx_done_tick) begin
      if (state == ST_CMD)  cmd_q  <= rx_data;
      if (state == ST_DATA) data_q <= rx_data;
    end
  end

  // Inter-byte timeout counter: idle at zero, restarted by every byte, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                              cnt <= '0;
    else if (state == ST_IDLE || rx_done_tick || tmo_hit)   cnt <= '0;
    else if (s_tick && cnt != CNT_LAST)                     cnt <= cnt + CNT_W'(1);
  end

  // Output holding register with handshake; a full register drops the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frm_valid   <= 1'b0;
      frm_cmd     <= 8'h00;
      frm_data    <= 8'h00;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= frame_done && frm_valid && !frm_ready;
      if (frame_done && !(frm_valid && !frm_ready)) begin
        frm_valid <= 1'b1;
        frm_cmd   <= cmd_q;
        frm_data  <= done_data;
      end else if (frm_valid && frm_ready) begin
        frm_valid <= 1'b0;
      end
    end
  end

  // Registered error pulses for timeout and checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_timeout <= 1'b0;
    else       err_timeout <= tmo_hit;
  end

`ifdef UART_FRAME_CHK_EN
  // Checksum error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_chk <= 1'b0;
    else       err_chk <= chk_bad;
  end
`else
  assign err_chk = 1'b0;
  logic unused_chk;
  assign unused_chk = chk_bad;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed testbench for uart_frame_rx; follows UART_FRAME_CHK_EN like the design.
module tb_uart_frame_rx;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       frm_valid;
  logic       frm_ready;
  logic [7:0] frm_cmd;
  logic [7:0] frm_data;
  logic       err_chk;
  logic       err_timeout;
  logic       err_overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_frame_rx #(.SOF(8'hA5), .TIMEOUT_TICKS(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .frm_valid    (frm_valid),
    .frm_ready    (frm_ready),
    .frm_cmd      (frm_cmd),
    .frm_data     (frm_data),
    .err_chk      (err_chk),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; outputs are sampled 1ns after the capturing edge.
  task automatic send_byte(input logic [7:0] b, input logic tick, input logic rdy);
    @(posedge clk); #1;
    rx_data = b; rx_done_tick = 1'b1; s_tick = tick; frm_ready = rdy;
    @(posedge clk); #1;
    rx_done_tick = 1'b0; s_tick = 1'b0; frm_ready = 1'b0;
  endtask

  task automatic tick_once();
    @(posedge clk); #1; s_tick = 1'b1;
    @(posedge clk); #1; s_tick = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic consume();
    @(posedge clk); #1; frm_ready = 1'b1;
    @(posedge clk); #1; frm_ready = 1'b0;
  endtask

  // Complete frame; the last byte optionally carries frm_ready.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k,
                            input logic rdy_last);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(c, 1'b0, 1'b0);
`ifdef UART_FRAME_CHK_EN
    send_byte(d, 1'b0, 1'b0);
    send_byte(k, 1'b0, rdy_last);
`else
    send_byte(d, 1'b0, rdy_last);
    if (k == 8'h00) $display("note: zero checksum argument");
`endif
  endtask

  initial begin
    reset = 1'b1; s_tick = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00; frm_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {7'd0, frm_valid}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_cmd", frm_cmd, 8'h00);
    check("rst_data", frm_data, 8'h00);
    check("rst_errs", {5'd0, err_chk, err_timeout, err_overrun}, 8'h00);
    reset = 1'b0;
    idle_cycle();

    // Basic frame, latency and handshake.
    send_frame(8'h12, 8'h34, 8'h83, 1'b0);
    check("f1_valid", {7'd0, frm_valid}, 8'h01);
    check("f1_cmd", frm_cmd, 8'h12);
    check("f1_data", frm_data, 8'h34);
    check("f1_busy", {7'd0, busy}, 8'h00);
    idle_cycle();
    check("f1_hold", {7'd0, frm_valid}, 8'h01);
    consume();
    check("f1_drop", {7'd0, frm_valid}, 8'h00);

    // Garbage before SOF is ignored.
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    check("junk_busy", {7'd0, busy}, 8'h00);
    send_frame(8'h01, 8'h02, 8'hA6, 1'b0);
    check("f2_valid", {7'd0, frm_valid}, 8'h01);
    check("f2_cmd", frm_cmd, 8'h01);
    check("f2_data", frm_data, 8'h02);
    consume();

`ifdef UART_FRAME_CHK_EN
    // Bad checksum.
    send_frame(8'h01, 8'h02, 8'h00, 1'b0);
    check("chk_err", {7'd0, err_chk}, 8'h01);
    check("chk_valid", {7'd0, frm_valid}, 8'h00);
    check("chk_busy", {7'd0, busy}, 8'h00);
    idle_cycle();
    check("chk_once", {7'd0, err_chk}, 8'h00);
`else
    check("chk_tied", {7'd0, err_chk}, 8'h00);
`endif

    // Timeout after a partial frame.
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) tick_once();
    check("to_early", {7'd0, err_timeout}, 8'h00);
    check("to_busy_pre", {7'd0, busy}, 8'h01);
    tick_once();
    check("to_pulse", {7'd0, err_timeout}, 8'h01);
    check("to_idle", {7'd0, busy}, 8'h00);
    idle_cycle();
    check("to_once", {7'd0, err_timeout}, 8'h00);
    send_frame(8'h03, 8'h04, 8'hA2, 1'b0);
    check("f3_valid", {7'd0, frm_valid}, 8'h01);
    check("f3_cmd", frm_cmd, 8'h03);
    check("f3_data", frm_data, 8'h04);
    consume();

    // Byte coinciding with the expiring tick wins.
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) tick_once();
`ifdef UART_FRAME_CHK_EN
    send_byte(8'h02, 1'b1, 1'b0);
    check("race_no_to", {7'd0, err_timeout}, 8'h00);
    check("race_busy", {7'd0, busy}, 8'h01);
    send_byte(8'hA6, 1'b0, 1'b0);
`else
    send_byte(8'h02, 1'b1, 1'b0);
    check("race_no_to", {7'd0, err_timeout}, 8'h00);
`endif
    check("race_valid", {7'd0, frm_valid}, 8'h01);
    check("race_data", frm_data, 8'h02);
    consume();

    // Overrun while held, then coincident accept.
    send_frame(8'h11, 8'h22, 8'h96, 1'b0);
    send_frame(8'h33, 8'h44, 8'hD2, 1'b0);
    check("ovr_pulse", {7'd0, err_overrun}, 8'h01);
    check("ovr_valid", {7'd0, frm_valid}, 8'h01);
    check("ovr_cmd", frm_cmd, 8'h11);
    check("ovr_data", frm_data, 8'h22);
    idle_cycle();
    check("ovr_once", {7'd0, err_overrun}, 8'h00);
    send_frame(8'h55, 8'h66, 8'h96, 1'b1);
    check("co_no_ovr", {7'd0, err_overrun}, 8'h00);
    check("co_valid", {7'd0, frm_valid}, 8'h01);
    check("co_cmd", frm_cmd, 8'h55);
    check("co_data", frm_data, 8'h66);
    consume();
    check("co_drop", {7'd0, frm_valid}, 8'h00);

    // Reset mid-frame with a frame held.
    send_frame(8'h21, 8'h43, 8'hC7, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mrst_busy", {7'd0, busy}, 8'h00);
    check("mrst_valid", {7'd0, frm_valid}, 8'h00);
    check("mrst_errs", {5'd0, err_chk, err_timeout, err_overrun}, 8'h00);
    idle_cycle();
    reset = 1'b0;
    send_frame(8'h07, 8'h08, 8'hAA, 1'b0);
    check("f4_valid", {7'd0, frm_valid}, 8'h01);
    check("f4_cmd", frm_cmd, 8'h07);
    check("f4_data", frm_data, 8'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
